simmem_release_scheduler: RTL and testbench
===========================================

// Module: simmem_release_scheduler
//
// PURPOSE
// Controller that sequences the write-response delay bank. It allocates a free entry identifier
// to each incoming response, then arbitrates round-robin among entries whose delay has expired.
// Each winner is presented on a registered valid/ready output. On handshake it pulses the
// per-entry released-onehot back to the delay bank and returns the entry to the free pool.
// Sits between the response input handshake and the response memory bank read port.
//
// PARAMETERS
// NumEntries  simmem_pkg::WriteRespBankTotalCapacity (16)  number of delay-bank entries
// IdWidth     $clog2(NumEntries)                           entry identifier width
//
// PORTS
// clk_i                      in   1             clock
// rst_ni                     in   1             async reset, active low
// in_valid_i                 in   1             new response requests an entry
// in_ready_o                 out  1             a free entry exists
// alloc_id_o                 out  IdWidth       entry granted on the input handshake
// release_en_i               in   NumEntries    multihot: entry delay expired (from delay bank)
// address_released_onehot_o  out  NumEntries    onehot pulse: entry released (to delay bank)
// out_valid_o                out  1             an expired entry is presented
// out_ready_i                in   1             downstream accepts presented entry
// out_id_o                   out  IdWidth       presented entry identifier
// occupancy_o                out  IdWidth+1     number of allocated entries
//
// BEHAVIOUR
// - Reset (async, rst_ni=0): occupied_q='0, out_valid_o=0, out_id_o=0, rr pointer=0,
//   occupancy_o=0, address_released_onehot_o='0. Mid-operation reset drops all entries.
// - Allocation (combinational):
//   - in_ready_o = |~occupied_q.
//   - alloc_id_o = lowest index with occupied_q==0.
//   - Input handshake (in_valid_i & in_ready_o) sets occupied_q[alloc_id_o] at the next edge.
// - Candidates = release_en_i & occupied_q & ~presented_mask.
//   - presented_mask = onehot(out_id_o) while out_valid_o, else '0.
//   - release_en_i bits of unoccupied entries are ignored; assertion flags them.
// - Arbiter: round-robin over candidates. Search starts at index ptr_q, wrapping at
//   NumEntries-1 -> 0. After loading winner k, ptr_q <= (k+1) mod NumEntries.
// - Output register, 2 states: EMPTY (out_valid_o=0) and PRESENT (out_valid_o=1).
//   - EMPTY, any candidate: load winner -> PRESENT next cycle (1-cycle min latency from
//     release_en_i).
//   - PRESENT, !out_ready_i: hold out_id_o stable (AXI rule: valid never drops without handshake).
//   - PRESENT, out_ready_i (handshake): address_released_onehot_o = onehot(out_id_o) this same
//     cycle (combinational, single pulse). Clear occupied_q[out_id_o] at the edge.
//   - After the handshake, load the next winner in the same edge if any candidate exists
//     (back-to-back throughput 1/cycle). Otherwise go to EMPTY.
// - A released entry is reallocatable from the cycle after handshake; never in the handshake
//   cycle.
// - Simultaneous allocation and release in one cycle: occupancy_o unchanged.
//   - Allocation alone: +1. Release alone: -1.
// - Full (occupancy_o==NumEntries): in_ready_o=0; in_valid_i is held by upstream.
// - Empty: out_valid_o=0; address_released_onehot_o='0.
// - alloc_id_o feeds the delay bank local identifier (zero-extended by integrator).
//
// STRUCTURE
// - simmem_pkg: NumEntries constant (= WriteRespBankTotalCapacity), IdWidth, typedef
//   entry_id_t.
// - Sub-module simmem_rr_arbiter:
//   - Combinational; inputs req multihot and ptr; outputs gnt_valid and gnt_id.
//   - Uses a double-width masked priority search.
//   - Reusable for other bank schedulers.
// - Top keeps occupied_q, ptr_q, out_valid_q, out_id_q and the free-entry priority encoder.
//
// TESTING
// 1. Reset, in_valid_i=1 for 16 cycles -> alloc ids 0..15 in order; in_ready_o=0 after 16th;
//    occupancy_o=16.
// 2. Alloc 0,1,2; release_en_i=3'b111 held, out_ready_i=1 -> out_id_o 0,1,2 on consecutive
//    cycles; onehot 001,010,100.
// 3. Entry 5 presented, out_ready_i=0 for 4 cycles -> out_valid_o/out_id_o=5 stable;
//    no released pulse until ready.
// 4. Alloc all 16, release 15 then 0: ptr wraps -> after id 15 grant, next winner 0 before 1.
// 5. Full bank, handshake of id 7 with in_valid_i=1 -> in_ready_o=0 that cycle;
//    next cycle alloc_id_o=7, occupancy stays 16 over the pair.
// 6. Assert rst_ni low while PRESENT with 10 occupied -> out_valid_o=0, occupancy_o=0,
//    alloc_id_o=0 immediately.

Source files
------------

// File: rtl/simmem_pkg.sv
// Shared constants and types for the simmem write-response release scheduler.
// Holds the bank capacity, identifier width, entry id type and output FSM states.
package simmem_pkg;

   localparam int unsigned WriteRespBankTotalCapacity = 16;
   localparam int unsigned NumEntries = WriteRespBankTotalCapacity;
   localparam int unsigned IdWidth = $clog2(NumEntries);

   typedef logic [IdWidth-1:0] entry_id_t;

   typedef enum logic {
      OutEmpty   = 1'b0,
      OutPresent = 1'b1
   } out_state_e;

   function automatic logic [NumEntries-1:0] id_onehot(entry_id_t id);
      logic [NumEntries-1:0] one;
      one = {{(NumEntries-1){1'b0}}, 1'b1};
      return one << id;
   endfunction

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Combinational round-robin arbiter: lowest request at or above ptr_i wins, wrapping.
// Ports: req_i multihot requests, ptr_i search start, gnt_valid_o any request, gnt_id_o winner.
module simmem_rr_arbiter #(
   parameter  int unsigned N = 16,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic         gnt_valid_o,
   output logic [W-1:0] gnt_id_o
);

   logic [2*N-1:0] req2;
   logic [2*N-1:0] mask2;
   logic [2*N-1:0] cand2;

   // Upper copy of req_i is unmasked, so requests below ptr_i act as the wrap.
   always_comb begin
      req2 = {req_i, req_i};
      mask2 = {(2*N){1'b1}} << ptr_i;
      cand2 = req2 & mask2;
      gnt_valid_o = |req_i;
      gnt_id_o = '0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (cand2[i]) gnt_id_o = W'(i % N);
      end
   end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Allocates delay-bank entries and releases expired ones round-robin on a valid/ready port.
// Ports: in_* allocation handshake, release_en_i expiry, out_* release handshake, occupancy_o.
module simmem_release_scheduler
   import simmem_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output entry_id_t             alloc_id_o,
   input  logic [NumEntries-1:0] release_en_i,
   output logic [NumEntries-1:0] address_released_onehot_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output entry_id_t             out_id_o,
   output logic [IdWidth:0]      occupancy_o
);

   localparam logic [IdWidth:0] OccOne = 1;
   localparam entry_id_t IdOne = 1;
   localparam entry_id_t IdLast = entry_id_t'(NumEntries - 1);

   logic [NumEntries-1:0] occupied_q, occupied_d;
   entry_id_t             ptr_q, ptr_d;
   entry_id_t             out_id_q, out_id_d;
   logic [IdWidth:0]      occ_q, occ_d;
   out_state_e            state_q, state_d;

   logic [NumEntries-1:0] presented;
   logic [NumEntries-1:0] cand;
   logic                  gnt_valid;
   entry_id_t             gnt_id;
   logic                  alloc;
   logic                  hs;
   logic                  load;

   // Free-entry priority encoder: lowest unoccupied index.
   always_comb begin
      alloc_id_o = '0;
      for (int i = NumEntries-1; i >= 0; i--) begin
         if (!occupied_q[i]) alloc_id_o = entry_id_t'(i);
      end
   end

   assign in_ready_o = ~&occupied_q;
   assign alloc = in_valid_i & in_ready_o;

   // The entry on the output must not win again while it waits.
   assign presented = (state_q == OutPresent) ? id_onehot(out_id_q) : '0;
   assign cand = release_en_i & occupied_q & ~presented;

   simmem_rr_arbiter #(.N(NumEntries)) u_arb (
      .req_i      (cand),
      .ptr_i      (ptr_q),
      .gnt_valid_o(gnt_valid),
      .gnt_id_o   (gnt_id)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= OutEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         OutEmpty:   if (gnt_valid) state_d = OutPresent;
         OutPresent: if (out_ready_i && !gnt_valid) state_d = OutEmpty;
         default:    state_d = OutEmpty;
      endcase
   end

   always_comb begin
      out_valid_o = (state_q == OutPresent);
      hs = out_valid_o & out_ready_i;
      address_released_onehot_o = hs ? id_onehot(out_id_q) : '0;
   end

   assign load = gnt_valid & (~out_valid_o | hs);

   always_comb begin
      occupied_d = occupied_q;
      if (alloc) occupied_d[alloc_id_o] = 1'b1;
      if (hs) occupied_d[out_id_q] = 1'b0;
      out_id_d = load ? gnt_id : out_id_q;
      ptr_d = ptr_q;
      if (load) ptr_d = (gnt_id == IdLast) ? '0 : gnt_id + IdOne;
      occ_d = occ_q;
      if (alloc && !hs) occ_d = occ_q + OccOne;
      if (!alloc && hs) occ_d = occ_q - OccOne;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         occupied_q <= '0;
         ptr_q <= '0;
         out_id_q <= '0;
         occ_q <= '0;
      end else begin
         occupied_q <= occupied_d;
         ptr_q <= ptr_d;
         out_id_q <= out_id_d;
         occ_q <= occ_d;
      end
   end

   assign out_id_o = out_id_q;
   assign occupancy_o = occ_q;

   // Expiry of an entry that is not allocated indicates a delay-bank fault.
   a_release_occupied : assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (release_en_i & ~occupied_q) == '0
   );

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Self-checking bench for simmem_release_scheduler.
// Directed scenarios plus random traffic against an entry-table reference model.
module tb_simmem_release_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  alloc_id;
   logic [15:0] release_en = '0;
   logic [15:0] onehot;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_id;
   logic [4:0]  occupancy;

   int passed = 0;
   int total = 0;

   logic [15:0] m_occ;
   bit          m_valid;
   int          m_id;
   int          m_ptr;

   always #5 clk = ~clk;

   simmem_release_scheduler dut (
      .clk_i                    (clk),
      .rst_ni                   (rst_n),
      .in_valid_i               (in_valid),
      .in_ready_o               (in_ready),
      .alloc_id_o               (alloc_id),
      .release_en_i             (release_en),
      .address_released_onehot_o(onehot),
      .out_valid_o              (out_valid),
      .out_ready_i              (out_ready),
      .out_id_o                 (out_id),
      .occupancy_o              (occupancy)
   );

   function automatic int first_free();
      for (int i = 0; i < 16; i++) if (!m_occ[i]) return i;
      return 0;
   endfunction

   function automatic int pop_occ();
      int n = 0;
      for (int i = 0; i < 16; i++) n += int'(m_occ[i]);
      return n;
   endfunction

   task automatic model_clear();
      m_occ = '0;
      m_valid = 0;
      m_id = 0;
      m_ptr = 0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      release_en = '0;
      out_ready = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive inputs; expiry is only ever reported for allocated entries.
   task automatic drive(bit v, logic [15:0] want, bit rdy);
      in_valid = v;
      release_en = want & m_occ;
      out_ready = rdy;
      #1;
   endtask

   // Advance one clock, applying the entry-table rules to the model.
   task automatic tick();
      logic [15:0] occ_n;
      logic [15:0] cand;
      bit v_n;
      int id_n;
      int ptr_n;
      bit hs;
      occ_n = m_occ;
      v_n = m_valid;
      id_n = m_id;
      ptr_n = m_ptr;
      hs = m_valid && out_ready;
      cand = release_en & m_occ;
      if (m_valid) cand[m_id] = 1'b0;
      if (in_valid && m_occ != 16'hffff) occ_n[first_free()] = 1'b1;
      if (hs) occ_n[m_id] = 1'b0;
      if (!m_valid || hs) begin
         v_n = 0;
         for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (m_ptr + k) % 16;
            if (cand[idx]) begin
               v_n = 1;
               id_n = idx;
               ptr_n = (idx + 1) % 16;
               break;
            end
         end
      end
      @(posedge clk);
      m_occ = occ_n;
      m_valid = v_n;
      m_id = id_n;
      m_ptr = ptr_n;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      drive(0, '0, 0);
      total++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid);
      else passed++;
      total++;
      if (occupancy !== 5'd0) $display("FAIL reset_occ got %0d want 0", occupancy);
      else passed++;
      total++;
      if (onehot !== 16'h0) $display("FAIL reset_onehot got %h want 0000", onehot);
      else passed++;
      total++;
      if (out_id !== 4'd0) $display("FAIL reset_out_id got %0d want 0", out_id);
      else passed++;
      total++;
      if (in_ready !== 1'b1 || alloc_id !== 4'd0)
         $display("FAIL reset_alloc got rdy=%0b id=%0d want rdy=1 id=0", in_ready, alloc_id);
      else passed++;
   endtask

   task automatic test_fill();
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1, '0, 0);
         total++;
         if (in_ready !== 1'b1 || alloc_id !== 4'(i))
            $display("FAIL fill_alloc got rdy=%0b id=%0d want rdy=1 id=%0d", in_ready, alloc_id, i);
         else passed++;
         tick();
      end
      drive(1, '0, 0);
      total++;
      if (in_ready !== 1'b0) $display("FAIL fill_full_ready got %0b want 0", in_ready);
      else passed++;
      total++;
      if (occupancy !== 5'd16) $display("FAIL fill_occ got %0d want 16", occupancy);
      else passed++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, '0, 0);
         tick();
      end
      drive(0, 16'h0007, 1);
      total++;
      if (out_valid !== 1'b0) $display("FAIL b2b_latency got %0b want 0", out_valid);
      else passed++;
      tick();
      for (int j = 0; j < 3; j++) begin
         drive(0, 16'h0007, 1);
         total++;
         if (out_valid !== 1'b1 || out_id !== 4'(j))
            $display("FAIL b2b_id got v=%0b id=%0d want v=1 id=%0d", out_valid, out_id, j);
         else passed++;
         total++;
         if (onehot !== (16'h1 << j))
            $display("FAIL b2b_onehot got %h want %h", onehot, 16'h1 << j);
         else passed++;
         tick();
      end
      drive(0, '0, 0);
      total++;
      if (out_valid !== 1'b0 || occupancy !== 5'd0)
         $display("FAIL b2b_drain got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy);
      else passed++;
   endtask

   task automatic test_stall();
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1, '0, 0);
         tick();
      end
      drive(0, 16'h0020, 0);
      tick();
      for (int c = 0; c < 4; c++) begin
         drive(0, 16'h0020, 0);
         total++;
         if (out_valid !== 1'b1 || out_id !== 4'd5 || onehot !== 16'h0)
            $display("FAIL stall_hold got v=%0b id=%0d oh=%h want v=1 id=5 oh=0000",
                     out_valid, out_id, onehot);
         else passed++;
         tick();
      end
      drive(0, 16'h0020, 1);
      total++;
      if (onehot !== 16'h0020) $display("FAIL stall_release got %h want 0020", onehot);
      else passed++;
      tick();
      drive(0, '0, 0);
      total++;
      if (out_valid !== 1'b0 || occupancy !== 5'd5)
         $display("FAIL stall_after got v=%0b occ=%0d want v=0 occ=5", out_valid, occupancy);
      else passed++;
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1, '0, 0);
         tick();
      end
      drive(0, 16'h0008, 1);
      tick();
      drive(0, 16'h8000, 1);
      total++;
      if (out_id !== 4'd3) $display("FAIL wrap_first got %0d want 3", out_id);
      else passed++;
      tick();
      drive(0, 16'h0023, 1);
      total++;
      if (out_id !== 4'd15 || onehot !== 16'h8000)
         $display("FAIL wrap_15 got id=%0d oh=%h want id=15 oh=8000", out_id, onehot);
      else passed++;
      tick();
      drive(0, 16'h0022, 1);
      total++;
      if (out_id !== 4'd0) $display("FAIL wrap_to_0 got %0d want 0", out_id);
      else passed++;
      tick();
      drive(0, '0, 1);
      total++;
      if (out_id !== 4'd1) $display("FAIL wrap_then_1 got %0d want 1", out_id);
      else passed++;
      tick();
   endtask

   task automatic test_full_swap();
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1, '0, 0);
         tick();
      end
      drive(0, 16'h0080, 0);
      tick();
      drive(1, 16'h0080, 1);
      total++;
      if (in_ready !== 1'b0 || onehot !== 16'h0080)
         $display("FAIL swap_hs got rdy=%0b oh=%h want rdy=0 oh=0080", in_ready, onehot);
      else passed++;
      tick();
      drive(1, '0, 0);
      total++;
      if (in_ready !== 1'b1 || alloc_id !== 4'd7 || occupancy !== 5'd15)
         $display("FAIL swap_realloc got rdy=%0b id=%0d occ=%0d want rdy=1 id=7 occ=15",
                  in_ready, alloc_id, occupancy);
      else passed++;
      tick();
      drive(0, '0, 0);
      total++;
      if (occupancy !== 5'd16) $display("FAIL swap_occ got %0d want 16", occupancy);
      else passed++;
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         logic [15:0] want;
         logic [15:0] exp_oh;
         want = 16'($urandom) & 16'($urandom);
         drive(($urandom % 3) != 0, want, ($urandom % 4) != 0);
         exp_oh = (m_valid && out_ready) ? (16'h1 << m_id) : 16'h0;
         total++;
         if (in_ready !== (m_occ != 16'hffff))
            $display("FAIL rnd_ready c=%0d got %0b", c, in_ready);
         else passed++;
         if (m_occ != 16'hffff) begin
            total++;
            if (alloc_id !== 4'(first_free()))
               $display("FAIL rnd_alloc c=%0d got %0d want %0d", c, alloc_id, first_free());
            else passed++;
         end
         total++;
         if (out_valid !== m_valid)
            $display("FAIL rnd_valid c=%0d got %0b want %0b", c, out_valid, m_valid);
         else passed++;
         if (m_valid) begin
            total++;
            if (out_id !== 4'(m_id))
               $display("FAIL rnd_id c=%0d got %0d want %0d", c, out_id, m_id);
            else passed++;
         end
         total++;
         if (onehot !== exp_oh)
            $display("FAIL rnd_onehot c=%0d got %h want %h", c, onehot, exp_oh);
         else passed++;
         total++;
         if (occupancy !== 5'(pop_occ()))
            $display("FAIL rnd_occ c=%0d got %0d want %0d", c, occupancy, pop_occ());
         else passed++;
         tick();
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, '0, 0);
         tick();
      end
      drive(0, 16'h0010, 0);
      tick();
      drive(0, 16'h0010, 0);
      total++;
      if (out_valid !== 1'b1 || occupancy !== 5'd10)
         $display("FAIL mrst_pre got v=%0b occ=%0d want v=1 occ=10", out_valid, occupancy);
      else passed++;
      #1;
      rst_n = 1'b0;
      release_en = '0;
      #1;
      total++;
      if (out_valid !== 1'b0 || occupancy !== 5'd0 || alloc_id !== 4'd0 || onehot !== 16'h0)
         $display("FAIL mrst_now got v=%0b occ=%0d id=%0d oh=%h want v=0 occ=0 id=0 oh=0000",
                  out_valid, occupancy, alloc_id, onehot);
      else passed++;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, '0, 0);
      total++;
      if (in_ready !== 1'b1 || alloc_id !== 4'd0)
         $display("FAIL mrst_after got rdy=%0b id=%0d want rdy=1 id=0", in_ready, alloc_id);
      else passed++;
      tick();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_back_to_back();
      test_stall();
      test_wrap();
      test_full_swap();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
